// File: rtl/atri_event_readout.sv
// Event readout framer: pulls words from the event FIFO and streams them as
// frames of header {HDR_MARK, frame count}, length N, N payload words and a
// 16-bit wrap-around checksum. A two-entry holding buffer plus a bypass path
// from dat_i keeps the stream at one word per cycle while the FIFO has data.
//
// Handshake: a word moves when out_valid_o and out_ready_i are both high on a
// rising clk edge. While out_valid_o is high and out_ready_i is low, every
// output field is held, and out_valid_o stays high until the word is taken.
module atri_event_readout #(
  parameter int          MAX_FRAME = 256,
  parameter logic [7:0]  HDR_MARK  = 8'hEB
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        fifo_empty_i,
  input  logic [15:0] fifo_nwords_i,
  output logic        fifo_rd_o,
  input  logic [15:0] dat_i,
  input  logic [1:0]  type_i,
  output logic [15:0] out_dat_o,
  output logic [1:0]  out_type_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_sof_o,
  output logic        out_eof_o,
  output logic [7:0]  frame_cnt_o,
  output logic [2:0]  state_o
);

  localparam logic [15:0] MAX_N = 16'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_PAY  = 3'd3,
    S_CKS  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] n_len;    // payload words in the current frame
  logic [15:0] rd_cnt;   // FIFO reads issued this frame
  logic [15:0] ld_cnt;   // payload words loaded into the output register
  logic [15:0] cks;      // running payload sum
  logic        rd_pend;  // a read was issued last cycle; its data is on dat_i
  logic [1:0]  occ;      // holding buffer occupancy
  logic [17:0] buf0;     // buffer head {type, dat}
  logic [17:0] buf1;

  logic        acc;
  logic        out_free;
  logic        src_avail;
  logic [17:0] in_word;
  logic [17:0] src_word;
  logic        load_pay;
  logic        pop;
  logic        push;
  logic        start;
  logic [15:0] n_start;

  assign state_o = state;

  // Next-word selection, buffer push/pop and the FIFO read strobe.
  always_comb begin
    acc       = out_valid_o & out_ready_i;
    out_free  = ~out_valid_o | acc;
    in_word   = {type_i, dat_i};
    src_avail = (occ != 2'd0) | rd_pend;
    // Oldest word first: buffer head, otherwise bypass the word arriving now.
    src_word  = (occ != 2'd0) ? buf0 : in_word;
    load_pay  = src_avail && (ld_cnt < n_len) &&
                (((state == S_LEN) && acc) || ((state == S_PAY) && out_free));
    pop       = load_pay && (occ != 2'd0);
    push      = rd_pend && !(load_pay && (occ == 2'd0));
    start     = enable_i && (fifo_nwords_i != 16'd0);
    n_start   = (fifo_nwords_i > MAX_N) ? MAX_N : fifo_nwords_i;
    fifo_rd_o = 1'b0;
    if (((state == S_HDR) || (state == S_LEN) || (state == S_PAY)) &&
        !fifo_empty_i && (rd_cnt < n_len) &&
        (({1'b0, occ} + {2'b00, rd_pend}) < 3'd2))
      fifo_rd_o = 1'b1;
  end

  // Frame sequencing, holding buffer and registered stream outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      n_len       <= '0;
      rd_cnt      <= '0;
      ld_cnt      <= '0;
      cks         <= '0;
      rd_pend     <= 1'b0;
      occ         <= '0;
      buf0        <= '0;
      buf1        <= '0;
      out_dat_o   <= '0;
      out_type_o  <= '0;
      out_valid_o <= 1'b0;
      out_sof_o   <= 1'b0;
      out_eof_o   <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      rd_pend <= fifo_rd_o;
      if (fifo_rd_o)
        rd_cnt <= rd_cnt + 16'd1;

      if (pop) begin
        if (occ == 2'd2) begin
          buf0 <= buf1;
          if (push)
            buf1 <= in_word;
        end else if (push) begin
          buf0 <= in_word;
        end
      end else if (push) begin
        if (occ == 2'd0)
          buf0 <= in_word;
        else
          buf1 <= in_word;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_HDR;
            n_len       <= n_start;
            rd_cnt      <= '0;
            ld_cnt      <= '0;
            cks         <= '0;
            out_valid_o <= 1'b1;
            out_sof_o   <= 1'b1;
            out_eof_o   <= 1'b0;
            out_type_o  <= 2'b00;
            out_dat_o   <= {HDR_MARK, frame_cnt_o};
          end
        end
        S_HDR: begin
          if (acc) begin
            state     <= S_LEN;
            out_sof_o <= 1'b0;
            out_dat_o <= n_len;
          end
        end
        S_LEN: begin
          if (acc) begin
            state       <= S_PAY;
            out_valid_o <= 1'b0;
          end
        end
        S_PAY: begin
          if (acc) begin
            if (ld_cnt == n_len) begin
              state      <= S_CKS;
              out_eof_o  <= 1'b1;
              out_type_o <= 2'b00;
              out_dat_o  <= cks;
            end else begin
              out_valid_o <= 1'b0;
            end
          end
        end
        S_CKS: begin
          if (acc) begin
            state       <= S_IDLE;
            out_valid_o <= 1'b0;
            out_eof_o   <= 1'b0;
            frame_cnt_o <= frame_cnt_o + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A payload load overrides the valid drop above when data is at hand.
      if (load_pay) begin
        out_valid_o <= 1'b1;
        out_dat_o   <= src_word[15:0];
        out_type_o  <= src_word[17:16];
        ld_cnt      <= ld_cnt + 16'd1;
        cks         <= cks + src_word[15:0];
      end
    end
  end

endmodule

// File: tb/tb_atri_event_readout.sv
// Bench for atri_event_readout: behavioural event FIFO, frame-level expected
// stream queue and a negedge monitor that compares each accepted word.
module tb_atri_event_readout;

  localparam int MAXF = 4;

  // ---------------- clock / reset / signals ----------------
  logic        clk           = 1'b0;
  logic        rst_n_i       = 1'b1;
  logic        enable_i      = 1'b0;
  logic        fifo_empty_i  = 1'b1;
  logic [15:0] fifo_nwords_i = 16'd0;
  logic        fifo_rd_o;
  logic [15:0] dat_i         = 16'd0;
  logic [1:0]  type_i        = 2'd0;
  logic [15:0] out_dat_o;
  logic [1:0]  out_type_o;
  logic        out_valid_o;
  logic        out_ready_i   = 1'b1;
  logic        out_sof_o;
  logic        out_eof_o;
  logic [7:0]  frame_cnt_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  atri_event_readout #(.MAX_FRAME(MAXF), .HDR_MARK(8'hEB)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .enable_i      (enable_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_nwords_i (fifo_nwords_i),
    .fifo_rd_o     (fifo_rd_o),
    .dat_i         (dat_i),
    .type_i        (type_i),
    .out_dat_o     (out_dat_o),
    .out_type_o    (out_type_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_sof_o     (out_sof_o),
    .out_eof_o     (out_eof_o),
    .frame_cnt_o   (frame_cnt_o),
    .state_o       (state_o)
  );

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [19:0] exp_q[$];       // {sof, eof, type, dat}
  logic [17:0] fifo_mem[$];    // {type, dat}
  logic [17:0] pend_words[$];  // loaded words not yet turned into expectations
  logic [7:0]  exp_cnt   = 8'd0;
  bit          force_empty = 1'b0;
  bit          rand_ready  = 1'b0;
  int          n_rd    = 0;
  int          cyc     = 0;
  int          sof_cyc = 0;
  int          eof_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h with nothing acceptable (t=%0t)", name, act, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [15:0] d, input logic [1:0] t);
    fifo_mem.push_back({t, d});
    pend_words.push_back({t, d});
  endtask

  // Turn pending words into whole frames of at most MAXF payload words.
  task automatic expect_frames();
    int          n;
    logic [15:0] sum;
    logic [17:0] w;
    while (pend_words.size() > 0) begin
      n = (pend_words.size() > MAXF) ? MAXF : pend_words.size();
      exp_q.push_back({4'b1000, 8'hEB, exp_cnt});
      exp_q.push_back({4'b0000, 16'(n)});
      sum = 16'd0;
      for (int i = 0; i < n; i++) begin
        w = pend_words.pop_front();
        sum = sum + w[15:0];
        exp_q.push_back({2'b00, w});
      end
      exp_q.push_back({4'b0100, sum});
      exp_cnt = exp_cnt + 8'd1;
    end
  endtask

  // Pulse reset; expectations restart from the unread FIFO contents.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_fifo_rd",    fifo_rd_o,   0);
    check("rst_out_valid",  out_valid_o, 0);
    check("rst_out_sof",    out_sof_o,   0);
    check("rst_out_eof",    out_eof_o,   0);
    check("rst_out_dat",    out_dat_o,   0);
    check("rst_out_type",   out_type_o,  0);
    check("rst_frame_cnt",  frame_cnt_o, 0);
    exp_q.delete();
    pend_words.delete();
    exp_cnt = 8'd0;
    foreach (fifo_mem[i]) pend_words.push_back(fifo_mem[i]);
    expect_frames();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (state_o == s) hit = 1'b1;
    end
    if (!hit) fail_now(name, {29'd0, state_o});
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state_o == 3'd0) hit = 1'b1;
    end
    if (!hit) fail_now(name, exp_q.size());
  endtask

  // ---------------- event FIFO model ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (fifo_rd_o) begin
        n_rd++;
        check("rd_while_empty", fifo_empty_i, 0);
        if (fifo_mem.size() > 0) {type_i, dat_i} <= fifo_mem.pop_front();
        else fail_now("rd_fifo_underflow", n_rd);
      end
      fifo_empty_i  <= (fifo_mem.size() == 0) || force_empty;
      fifo_nwords_i <= 16'(fifo_mem.size());
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [19:0] cur;
    logic [19:0] held;
    logic [19:0] e;
    bit          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      cur = {out_sof_o, out_eof_o, out_type_o, out_dat_o};
      if (!rst_n_i) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", out_valid_o, 1);
          if (out_valid_o) check("hold_word", cur, held);
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) fail_now("unexpected_word", cur);
          else begin
            e = exp_q.pop_front();
            check("stream_word", cur, e);
          end
          if (out_sof_o) sof_cyc = cyc;
          if (out_eof_o) eof_cyc = cyc;
        end
        stalled = out_valid_o && !out_ready_i;
        held    = cur;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd0;
    #1;
    do_reset();

    // A: three words, hand-computed frame, full throughput.
    @(negedge clk);
    load_word(16'h0001, 2'b01);
    load_word(16'h0002, 2'b00);
    load_word(16'hFFFF, 2'b10);
    pend_words.delete();
    exp_q.push_back({4'b1000, 16'hEB00});
    exp_q.push_back({4'b0000, 16'h0003});
    exp_q.push_back({4'b0001, 16'h0001});
    exp_q.push_back({4'b0000, 16'h0002});
    exp_q.push_back({4'b0010, 16'hFFFF});
    exp_q.push_back({4'b0100, 16'h0002});
    exp_cnt = 8'd1;
    repeat (2) @(negedge clk);
    enable_i = 1'b1;
    wait_drain(200, "a_drain_timeout");
    check("a_sof_to_eof_cycles", eof_cyc - sof_cyc, 5);
    check("a_frame_cnt", frame_cnt_o, 1);
    enable_i = 1'b0;

    // B: ten words with MAX_FRAME=4 -> lengths 4, 4, 2.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) load_word(16'h1000 + 16'(i), 2'(i));
    rd0 = n_rd;
    repeat (2) @(negedge clk);
    expect_frames();
    enable_i = 1'b1;
    wait_drain(400, "b_drain_timeout");
    check("b_read_count", n_rd - rd0, 10);
    check("b_frame_cnt", frame_cnt_o, 3);
    enable_i = 1'b0;

    // C: FIFO reports empty for five cycles in the middle of a payload.
    @(negedge clk);
    for (int i = 0; i < 8; i++) load_word(16'hA000 ^ (16'(i) * 16'h0111), 2'(i + 1));
    rd0 = n_rd;
    repeat (2) @(negedge clk);
    expect_frames();
    enable_i = 1'b1;
    wait_state(3'd3, 100, "c_pay_timeout");
    force_empty = 1'b1;
    repeat (5) @(negedge clk);
    force_empty = 1'b0;
    wait_drain(400, "c_drain_timeout");
    check("c_read_count", n_rd - rd0, 8);
    check("c_frame_cnt", frame_cnt_o, 5);
    enable_i = 1'b0;

    // D: reset in the middle of a payload, framing restarts on unread words.
    @(negedge clk);
    for (int i = 0; i < 6; i++) load_word(16'h5A00 + 16'(i), 2'(i));
    repeat (2) @(negedge clk);
    expect_frames();
    enable_i = 1'b1;
    wait_state(3'd3, 100, "d_pay_timeout");
    @(posedge clk);
    do_reset();
    wait_drain(400, "d_drain_timeout");
    check("d_frame_cnt", frame_cnt_o, 1);
    check("d_fifo_drained", fifo_mem.size(), 0);
    enable_i = 1'b0;

    // E: 257 frames under random ready throttling; counter wraps to 1.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 257 * MAXF; i++) load_word(16'(i * 37 + 5), 2'(i));
    rd0 = n_rd;
    repeat (2) @(negedge clk);
    expect_frames();
    rand_ready = 1'b1;
    enable_i = 1'b1;
    wait_drain(20000, "e_drain_timeout");
    check("e_read_count", n_rd - rd0, 257 * MAXF);
    check("e_frame_cnt_wrap", frame_cnt_o, 1);
    rand_ready = 1'b0;
    enable_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
